// File: rtl/uart_tx_arbiter.sv
// Shares one UART Tx between NUM_REQ byte sources; round-robin, or fixed priority when UART_TX_ARB_PRIORITY_EN is defined.
// Latency: req registered at edge N, grant/tx_data/owner/active after N+1, tx_send after N+2.
// Backpressure: no grant while a frame, its guard gap or en=0 holds the Tx; requesters hold req until granted.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int GUARD_TICKS = 1,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                         src_clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         baud_tick,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_send,
    input  logic                         tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         active,
    output logic                         err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GUARD_TICKS + 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GUARD     = 3'd4
    } state_e;

    state_e              state_q;
    logic [NUM_REQ-1:0]  req_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                tx_send_q;
    logic [IW-1:0]       owner_q;
    logic                active_q;
    logic                err_q;
    logic [AW-1:0]       ack_cnt_q;
    logic [GW-1:0]       guard_cnt_q;

    logic [NUM_REQ-1:0]  cand_d;
    logic                win_vld_d;
    logic [IW-1:0]       win_idx_d;
    logic [IW-1:0]       probe_idx;
    logic [DATA_W-1:0]   win_dat_d;
    int                  j;

    // Registered request ANDed with the live one: a source that drops req is never granted.
    always_comb begin
        cand_d    = req_q & req;
        win_vld_d = 1'b0;
        win_idx_d = '0;
        win_dat_d = '0;
        probe_idx = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef UART_TX_ARB_PRIORITY_EN
            j = i;
`else
            j = (int'(owner_q) + 1 + i) % NUM_REQ;
`endif
            probe_idx = IW'(j);
            if (!win_vld_d && cand_d[probe_idx]) begin
                win_vld_d = 1'b1;
                win_idx_d = probe_idx;
                win_dat_d = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            grant_q     <= '0;
            tx_data_q   <= '0;
            tx_send_q   <= 1'b0;
            owner_q     <= IW'(NUM_REQ - 1);
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            ack_cnt_q   <= '0;
            guard_cnt_q <= '0;
        end else begin
            req_q     <= req;
            grant_q   <= '0;
            tx_send_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && win_vld_d) begin
                        grant_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_d;
                        tx_data_q <= win_dat_d;
                        owner_q   <= win_idx_d;
                        active_q  <= 1'b1;
                        state_q   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_send_q <= 1'b1;
                    ack_cnt_q <= '0;
                    state_q   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (baud_tick) begin
                        if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                            err_q    <= 1'b1;
                            active_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            ack_cnt_q <= ack_cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (GUARD_TICKS == 0) begin
                            active_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            guard_cnt_q <= GW'(GUARD_TICKS);
                            state_q     <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (baud_tick) begin
                        if (guard_cnt_q == GW'(1)) begin
                            guard_cnt_q <= '0;
                            active_q    <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            guard_cnt_q <= guard_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign owner       = owner_q;
    assign active      = active_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a baud divider and a simple Tx busy model.
module tb_uart_tx_arbiter;

    logic        src_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        baud_tick = 1'b0;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy = 1'b0;
    logic [0:0]  owner;
    logic        active;
    logic        err_timeout;

    int n_chk = 0;
    int n_pass = 0;
    int send_cnt = 0;
    int grant_cnt = 0;
    int baud_div = 0;
    int model_n = 0;
    int busy_ticks = 10;
    logic ack_en = 1'b1;

    uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .GUARD_TICKS(1), .ACK_TIMEOUT(4)) dut (
        .src_clk(src_clk), .rst_n(rst_n), .en(en), .baud_tick(baud_tick),
        .req(req), .req_data(req_data), .grant(grant), .tx_data(tx_data),
        .tx_send(tx_send), .tx_busy(tx_busy), .owner(owner), .active(active),
        .err_timeout(err_timeout)
    );

    always #5 src_clk = ~src_clk;

    // One baud tick every 4 clocks.
    initial forever begin
        @(posedge src_clk);
        #1;
        baud_tick = (baud_div == 3);
        baud_div  = (baud_div + 1) % 4;
    end

    // Tx model: busy rises in the send cycle and lasts busy_ticks baud ticks.
    initial forever begin
        @(posedge src_clk);
        #2;
        if (tx_send && ack_en) begin
            tx_busy = 1'b1;
            model_n = 0;
            while (model_n < busy_ticks) begin
                @(posedge src_clk);
                #2;
                if (baud_tick) model_n++;
            end
            tx_busy = 1'b0;
        end
    end

    always @(negedge src_clk) begin
        if (tx_send) send_cnt++;
        if (grant != 2'b00) grant_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return active;
            1:       return tx_busy;
            default: return err_timeout;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic lvl);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge src_clk);
            if (probe(sel) == lvl) got = 1'b1;
        end
        chk({tag, "_seen"}, got, 1);
    endtask

    task automatic wait_grant(input string tag, output logic [1:0] g);
        logic got;
        got = 1'b0;
        g   = 2'b00;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge src_clk);
            if (grant != 2'b00) begin
                got = 1'b1;
                g   = grant;
            end
        end
        chk({tag, "_seen"}, got, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_send"}, tx_send, 0);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_owner"}, owner, 1);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    task automatic do_reset();
        @(negedge src_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge src_clk);
        rst_n = 1'b1;
    endtask

    logic [1:0] g;
    logic [1:0] exp_g [3];
    logic [1:0] exp_t4;
    int ticks;
    int s0;
    int gc;

    initial begin
`ifdef UART_TX_ARB_PRIORITY_EN
        exp_g  = '{2'b01, 2'b01, 2'b01};
        exp_t4 = 2'b01;
`else
        exp_g  = '{2'b01, 2'b10, 2'b01};
        exp_t4 = 2'b10;
`endif
        repeat (3) @(negedge src_clk);
        check_reset("rst");
        rst_n = 1'b1;
        en    = 1'b1;

        // Single source, byte 0x41
        s0       = send_cnt;
        req_data = 16'h0041;
        req      = 2'b01;
        wait_grant("t1", g);
        chk("t1_grant", g, 2'b01);
        chk("t1_data", tx_data, 8'h41);
        chk("t1_owner", owner, 0);
        chk("t1_active", active, 1);
        chk("t1_send_early", tx_send, 0);
        req = 2'b00;
        @(negedge src_clk);
        chk("t1_grant_pulse", grant, 0);
        chk("t1_send", tx_send, 1);
        @(negedge src_clk);
        chk("t1_send_pulse", tx_send, 0);
        wait_for("t1_busy_fall", 1, 1'b0);
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge src_clk);
            if (!active) break;
            if (baud_tick) ticks++;
        end
        chk("t1_guard_ticks", ticks, 1);
        chk("t1_send_count", send_cnt - s0, 1);
        chk("t1_data_hold", tx_data, 8'h41);

        // Both requesting: alternation and guard gap
        do_reset();
        req_data = 16'h3231;
        req      = 2'b11;
        for (int f = 0; f < 3; f++) begin
            wait_grant("t2", g);
            chk("t2_grant", g, exp_g[f]);
            chk("t2_data", tx_data, (exp_g[f] == 2'b01) ? 8'h31 : 8'h32);
            if (f == 2) req = 2'b00;
            wait_for("t2_busy_rise", 1, 1'b1);
            wait_for("t2_busy_fall", 1, 1'b0);
            ticks = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge src_clk);
                if (!active) break;
                if (baud_tick) ticks++;
            end
            chk("t2_gap", (ticks >= 1), 1);
        end

        // Tx never acknowledges
        ack_en   = 1'b0;
        req_data = 16'h0055;
        req      = 2'b01;
        wait_grant("t3", g);
        chk("t3_grant", g, 2'b01);
        req = 2'b00;
        @(negedge src_clk);
        chk("t3_send", tx_send, 1);
        chk("t3_err_pre", err_timeout, 0);
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            if (baud_tick) ticks++;
            @(negedge src_clk);
            if (err_timeout) break;
        end
        chk("t3_timeout_ticks", ticks, 4);
        chk("t3_err", err_timeout, 1);
        chk("t3_active", active, 0);
        ack_en   = 1'b1;
        req_data = 16'h6600;
        req      = 2'b10;
        wait_grant("t3b", g);
        chk("t3b_grant", g, 2'b10);
        chk("t3b_data", tx_data, 8'h66);
        chk("t3b_owner", owner, 1);
        chk("t3b_err_sticky", err_timeout, 1);
        req = 2'b00;
        wait_for("t3b_done", 0, 1'b0);

        // en dropped during WAIT_DONE
        req_data = 16'h3231;
        req      = 2'b11;
        wait_grant("t4", g);
        chk("t4_grant", g, 2'b01);
        wait_for("t4_busy", 1, 1'b1);
        en = 1'b0;
        gc = grant_cnt;
        wait_for("t4_done", 0, 1'b0);
        repeat (60) @(negedge src_clk);
        chk("t4_no_grant", grant_cnt - gc, 0);
        chk("t4_idle", active, 0);
        en = 1'b1;
        wait_grant("t4b", g);
        chk("t4b_grant", g, exp_t4);
        req = 2'b00;
        wait_for("t4b_done", 0, 1'b0);

        // Reset during WAIT_DONE
        req = 2'b11;
        wait_grant("t5", g);
        wait_for("t5_busy", 1, 1'b1);
        repeat (3) @(negedge src_clk);
        #2;
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        check_reset("t5_rst");
        s0 = send_cnt;
        repeat (2) @(negedge src_clk);
        rst_n = 1'b1;
        wait_for("t5_busy_fall", 1, 1'b0);
        repeat (5) @(negedge src_clk);
        chk("t5_no_send", send_cnt - s0, 0);
        req = 2'b11;
        wait_grant("t5b", g);
        chk("t5b_grant", g, 2'b01);
        req = 2'b00;
        wait_for("t5b_done", 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between `NUM_REQ` byte sources (manual switch entry, RX loopback echo, status reporter) and sequences every frame. It sits between the requesters and the `Tx` FSM: it arbitrates, latches the winning byte, pulses the Tx send input, tracks Tx busy to frame completion, and enforces an inter-frame guard gap counted in baud ticks. It also flags a Tx that never acknowledges a send.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `DATA_W`, default 8: byte width per requester.
- `GUARD_TICKS`, default 1: idle baud ticks inserted after each frame; 0 disables the gap.
- `ACK_TIMEOUT`, default 4: baud ticks allowed between `tx_send` and `tx_busy` rising.

- `src_clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: arbitration enable; low means no new grants.
- `baud_tick` in 1: one-`src_clk` enable pulse at Tx baud rate.
- `req` in `NUM_REQ`: level request per source; held until granted.
- `req_data` in `NUM_REQ*DATA_W`: source i byte at bits `[i*DATA_W +: DATA_W]`.
- `grant` out `NUM_REQ`: one-hot, one-cycle pulse; source drops/advances `req` after it.
- `tx_data` out `DATA_W`: latched byte to Tx; stable from grant until next grant.
- `tx_send` out 1: one-cycle start pulse to Tx.
- `tx_busy` in 1: Tx frame in progress.
- `owner` out `$clog2(NUM_REQ)`: index of last granted source.
- `active` out 1: high from grant until guard expiry.
- `err_timeout` out 1: sticky; set when Tx ignores a send.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GUARD.
- IDLE: if `en` and `|req`, select winner, latch `tx_data`, set `owner`, pulse `grant`, set `active` → LAUNCH. Otherwise stay.
- Round-robin: search begins at `owner+1` and wraps modulo `NUM_REQ`. A lone requester is granted repeatedly.
- LAUNCH: `tx_send`=1 for exactly one cycle → WAIT_BUSY. Clear the ack counter.
- WAIT_BUSY: `tx_busy`=1 → WAIT_DONE. Count `baud_tick`s; at `ACK_TIMEOUT` ticks set `err_timeout`, clear `active` → IDLE.
- WAIT_DONE: `tx_busy`=0 → GUARD with counter=`GUARD_TICKS`, or → IDLE (`active` cleared) if `GUARD_TICKS`=0.
- GUARD: decrement on `baud_tick`. When the count reaches 0, clear `active` → IDLE.
- Deasserting `en` mid-frame does not abort the frame. The frame completes and no grant follows.
- A `req` drop before grant withdraws the request. No grant is issued to a deasserted source.
- `err_timeout` clears only on reset.
- Reset values: state IDLE, `grant`=0, `tx_send`=0, `tx_data`=0, `owner`=`NUM_REQ-1` (first search starts at 0), `active`=0, `err_timeout`=0, counters 0.
- Reset mid-frame returns to IDLE immediately. No `tx_send` pulse is generated.

## Timing
- `req` sampled in IDLE at edge N → `grant`, `tx_data`, `owner`, `active` valid after edge N+1.
- `tx_send` is high in the cycle after edge N+2.
- Minimum grant-to-grant spacing = frame length + `GUARD_TICKS` baud ticks + 2 `src_clk`.
- `tx_busy` rising in the same cycle as `tx_send` is accepted at the next WAIT_BUSY evaluation.
- `baud_tick` coincident with a state entry is counted only in GUARD/WAIT_BUSY. It is counted if present while in that state.
- All outputs are registered. There is no combinational path from `req` to `grant`.

## Configuration
- `UART_TX_ARB_PRIORITY_EN` defined: fixed priority is used and the lowest index always wins. `owner` still reports the winner.
- Undefined: round-robin as specified above.

## Test plan
- Reset, `req`=2'b01, byte 0x41 → `grant`=01 one cycle, `tx_data`=0x41, single `tx_send` pulse. `active` falls 1 tick after `tx_busy` falls.
- Both requesting (0x31, 0x32), Tx model busy 10 ticks → grants alternate 01,10,01. Gap between frames is ≥1 baud tick.
- `tx_busy` held 0 after send, `ACK_TIMEOUT`=4 → `err_timeout`=1 after 4th tick. FSM returns to IDLE and the next request is granted.
- `en` dropped during WAIT_DONE with requests pending → current frame ends, no further `grant` until `en`=1.
- `rst_n` pulsed low in WAIT_DONE → all outputs at reset values asynchronously. First grant afterwards goes to source 0.
- With `UART_TX_ARB_PRIORITY_EN`, both requesting continuously → every grant goes to source 0.
